// File: rtl/cpu_pkg.sv
// Shared pipeline types and encodings for the RV32 five-stage core.
// The ID/EX bundles are consumed unchanged by the ID_EX register.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef struct packed {
    logic [31:0] pc_address;
    logic [31:0] reg_read_data1;
    logic [31:0] reg_read_data2;
    logic [31:0] imm;
    logic [3:0]  funct_inst_bits;
    logic [4:0]  rd;
  } id_ex_data_t;

  typedef struct packed {
    logic       WB_reg_write;
    logic       WB_mem_to_reg;
    logic       M_branch;
    logic       M_mem_read;
    logic       M_mem_write;
    logic       EX_ALU_Src;
    logic [1:0] EX_ALU_Op;
  } id_ex_control_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: async clear, one write port, two combinational
// read ports with write-to-read bypass; x0 is never stored and always reads 0.
module reg_file #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [4:0]      raddr [2];
  logic [XLEN-1:0] rdata [2];
  logic            wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  // Bypass stays live during reset so a pending write-back value is still visible.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rdata[gi] = '0;
        if (raddr[gi] != 5'd0) begin
          if (wr_en && waddr == raddr[gi]) rdata[gi] = wdata;
          else                             rdata[gi] = regs[raddr[gi]];
        end
      end
    end
  endgenerate

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule

// File: rtl/id_stage.sv
// Instruction decode: control generation, immediates, register reads and
// load-use hazard detection, all combinational from the IF/ID contents.
module id_stage
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     if_id_pc,
  input  logic [31:0]     if_id_instr,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output id_ex_data_t     data_out,
  output id_ex_control_t  control_out,
  output logic            stall
);

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [31:0]     imm;
  logic            rs1_used;
  logic            rs2_used;
  logic            hazard;
  id_ex_control_t  ctrl;

  assign opcode = if_id_instr[6:0];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];

  reg_file #(
    .NUM_REGS (NUM_REGS),
    .XLEN     (XLEN)
  ) u_reg_file (
    .clock  (clock),
    .reset  (reset),
    .we     (wb_reg_write),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always_comb begin
    ctrl     = '0;
    imm      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.WB_reg_write = 1'b1;
        ctrl.EX_ALU_Op    = ALUOP_R;
        rs1_used          = 1'b1;
        rs2_used          = 1'b1;
      end
      OP_IMM: begin
        ctrl.WB_reg_write = 1'b1;
        ctrl.EX_ALU_Src   = 1'b1;
        ctrl.EX_ALU_Op    = ALUOP_I;
        imm               = imm_i(if_id_instr);
        rs1_used          = 1'b1;
      end
      OP_LOAD: begin
        ctrl.WB_reg_write  = 1'b1;
        ctrl.WB_mem_to_reg = 1'b1;
        ctrl.M_mem_read    = 1'b1;
        ctrl.EX_ALU_Src    = 1'b1;
        ctrl.EX_ALU_Op     = ALUOP_MEM;
        imm                = imm_i(if_id_instr);
        rs1_used           = 1'b1;
      end
      OP_STORE: begin
        ctrl.M_mem_write = 1'b1;
        ctrl.EX_ALU_Src  = 1'b1;
        ctrl.EX_ALU_Op   = ALUOP_MEM;
        imm              = imm_s(if_id_instr);
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.M_branch  = 1'b1;
        ctrl.EX_ALU_Op = ALUOP_BR;
        imm            = imm_b(if_id_instr);
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      default: ;
    endcase
  end

  // Only operands the instruction actually reads can create a load-use hazard.
  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  (((ex_rd == rs1) && rs1_used) || ((ex_rd == rs2) && rs2_used));

  assign stall       = hazard && !reset;
  assign control_out = (hazard || flush || reset) ? '0 : ctrl;

  assign data_out.pc_address      = if_id_pc;
  assign data_out.reg_read_data1  = rdata1;
  assign data_out.reg_read_data2  = rdata2;
  assign data_out.imm             = imm;
  assign data_out.funct_inst_bits = {if_id_instr[30], if_id_instr[14:12]};
  assign data_out.rd              = if_id_instr[11:7];

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded instructions with hand-computed
// expected decode, register, bypass, hazard, flush and reset results.
module tb_id_stage;
  import cpu_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic [31:0]    if_id_pc;
  logic [31:0]    if_id_instr;
  logic           wb_reg_write;
  logic [4:0]     wb_rd;
  logic [31:0]    wb_data;
  logic           ex_mem_read;
  logic [4:0]     ex_rd;
  logic           flush;
  id_ex_data_t    data_out;
  id_ex_control_t control_out;
  logic           stall;
  logic [7:0]     ctrl_bits;

  int tests = 0;
  int fails = 0;

  // Control byte order: reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src, alu_op[1:0]
  localparam logic [7:0] C_R      = 8'b1000_0010;
  localparam logic [7:0] C_IMM    = 8'b1000_0111;
  localparam logic [7:0] C_LOAD   = 8'b1101_0100;
  localparam logic [7:0] C_STORE  = 8'b0000_1100;
  localparam logic [7:0] C_BRANCH = 8'b0010_0001;

  localparam logic [31:0] I_ADD_6_5_5  = 32'h0052_8333;
  localparam logic [31:0] I_SUB_6_5_5  = 32'h4052_8333;
  localparam logic [31:0] I_SW_7_M4_2  = 32'hFE71_2E23;
  localparam logic [31:0] I_ADDI_1_0_5 = 32'h0050_0093;
  localparam logic [31:0] I_BEQ_3_4_M8 = 32'hFE41_8CE3;
  localparam logic [31:0] I_LW_8_12_5  = 32'h00C2_A403;
  localparam logic [31:0] I_UNKNOWN    = 32'h0000_007F;
  localparam logic [31:0] I_ADD_10_9_9 = 32'h0094_8533;

  always #5 clock = ~clock;

  assign ctrl_bits = control_out;

  id_stage dut (
    .clock        (clock),
    .reset        (reset),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .flush        (flush),
    .data_out     (data_out),
    .control_out  (control_out),
    .stall        (stall)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset        = 1'b1;
    if_id_pc     = 32'h0;
    if_id_instr  = I_ADD_6_5_5;
    wb_reg_write = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'h0;
    ex_mem_read  = 1'b0;
    ex_rd        = 5'd0;
    flush        = 1'b0;

    // Reset state
    #2;
    $display("[TB] reset state");
    chk("rst_ctrl", {24'h0, ctrl_bits}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rd1", data_out.reg_read_data1, 32'h0);
    #10 reset = 1'b0;

    // 1: write x5=100, then add x6,x5,x5
    @(posedge clock); #1;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'd100;
    if_id_instr = I_UNKNOWN;
    @(posedge clock); #1;
    wb_reg_write = 1'b0;
    if_id_pc = 32'h0000_0040; if_id_instr = I_ADD_6_5_5;
    #1;
    $display("[TB] add x6,x5,x5");
    chk("add_rd1", data_out.reg_read_data1, 32'd100);
    chk("add_rd2", data_out.reg_read_data2, 32'd100);
    chk("add_ctrl", {24'h0, ctrl_bits}, {24'h0, C_R});
    chk("add_funct", {28'h0, data_out.funct_inst_bits}, 32'h0);
    chk("add_rdst", {27'h0, data_out.rd}, 32'd6);
    chk("add_imm", data_out.imm, 32'h0);
    chk("add_pc", data_out.pc_address, 32'h0000_0040);
    if_id_instr = I_SUB_6_5_5;
    #1;
    $display("[TB] sub x6,x5,x5");
    chk("sub_funct", {28'h0, data_out.funct_inst_bits}, 32'h8);

    // 2: same-cycle bypass on sw x7,-4(x2)
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    if_id_instr = I_SW_7_M4_2;
    #1;
    $display("[TB] sw x7,-4(x2) with bypass");
    chk("sw_rd2_bypass", data_out.reg_read_data2, 32'hDEAD_BEEF);
    chk("sw_rd1", data_out.reg_read_data1, 32'h0);
    chk("sw_imm", data_out.imm, 32'hFFFF_FFFC);
    chk("sw_ctrl", {24'h0, ctrl_bits}, {24'h0, C_STORE});
    @(posedge clock); #1;
    wb_reg_write = 1'b0;
    #1;
    chk("sw_rd2_array", data_out.reg_read_data2, 32'hDEAD_BEEF);

    // 3: write to x0 is discarded, both bypass and array
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'd55;
    if_id_instr = I_ADDI_1_0_5;
    #1;
    $display("[TB] addi x1,x0,5 during x0 write");
    chk("x0_bypass", data_out.reg_read_data1, 32'h0);
    @(posedge clock); #1;
    wb_reg_write = 1'b0;
    #1;
    $display("[TB] addi x1,x0,5");
    chk("addi_rd1", data_out.reg_read_data1, 32'h0);
    chk("addi_imm", data_out.imm, 32'd5);
    chk("addi_ctrl", {24'h0, ctrl_bits}, {24'h0, C_IMM});
    // rs2 field of an I-type is immediate bits, so no hazard
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    chk("addi_no_rs2_haz", {31'h0, stall}, 32'h0);

    // 4: load-use hazard on beq, then ex_rd=0
    ex_rd = 5'd3; if_id_instr = I_BEQ_3_4_M8;
    #1;
    $display("[TB] beq x3,x4,-8 hazard");
    chk("beq_stall", {31'h0, stall}, 32'h1);
    chk("beq_stall_ctrl", {24'h0, ctrl_bits}, 32'h0);
    ex_rd = 5'd4;
    #1;
    chk("beq_rs2_stall", {31'h0, stall}, 32'h1);
    ex_rd = 5'd0;
    #1;
    $display("[TB] beq x3,x4,-8 ex_rd=0");
    chk("beq_nostall", {31'h0, stall}, 32'h0);
    chk("beq_ctrl", {24'h0, ctrl_bits}, {24'h0, C_BRANCH});
    chk("beq_imm", data_out.imm, 32'hFFFF_FFF8);
    ex_mem_read = 1'b0; ex_rd = 5'd3;
    #1;
    chk("beq_noread", {31'h0, stall}, 32'h0);

    // 5: flush over a valid load, then unknown opcode
    if_id_instr = I_LW_8_12_5;
    #1;
    $display("[TB] lw x8,12(x5)");
    chk("lw_ctrl", {24'h0, ctrl_bits}, {24'h0, C_LOAD});
    chk("lw_imm", data_out.imm, 32'd12);
    flush = 1'b1;
    #1;
    $display("[TB] lw under flush");
    chk("flush_ctrl", {24'h0, ctrl_bits}, 32'h0);
    chk("flush_stall", {31'h0, stall}, 32'h0);
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    chk("flush_haz_stall", {31'h0, stall}, 32'h1);
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    if_id_instr = I_UNKNOWN;
    #1;
    $display("[TB] unknown opcode");
    chk("unk_ctrl", {24'h0, ctrl_bits}, 32'h0);
    chk("unk_imm", data_out.imm, 32'h0);

    // 6: write x9=42, async reset pulse mid-cycle clears it
    wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'd42;
    @(posedge clock); #1;
    wb_reg_write = 1'b0;
    if_id_instr = I_ADD_10_9_9;
    #1;
    $display("[TB] add x10,x9,x9 before reset");
    chk("x9_pre", data_out.reg_read_data1, 32'd42);
    ex_mem_read = 1'b1; ex_rd = 5'd9;
    reset = 1'b1;
    #1;
    $display("[TB] add x10,x9,x9 in reset");
    chk("rstmid_ctrl", {24'h0, ctrl_bits}, 32'h0);
    chk("rstmid_stall", {31'h0, stall}, 32'h0);
    chk("rstmid_rd1", data_out.reg_read_data1, 32'h0);
    #2;
    reset = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    $display("[TB] add x10,x9,x9 after reset");
    chk("x9_post", data_out.reg_read_data2, 32'h0);
    chk("post_ctrl", {24'h0, ctrl_bits}, {24'h0, C_R});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32 pipeline. It sits between the IF/ID register and `ID_EX`, and turns the fetched instruction into the `id_ex_data_t` / `id_ex_control_t` bundles that `ID_EX` latches. It owns the 32×32 architectural register file, including the write-back port and same-cycle write-to-read bypass. It also detects load-use hazards and inserts bubbles on hazards and flushes.

## Interface
Parameters:
- `NUM_REGS`, 32, register count; `x0` is hard-wired to zero.
- `XLEN`, 32, data width.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears the register file.
- `if_id_pc`  in  32  PC of the instruction in decode.
- `if_id_instr`  in  32  instruction word.
- `wb_reg_write`  in  1  write-back enable from MEM/WB.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  32  write-back value.
- `ex_mem_read`  in  1  `M_mem_read` of the instruction currently in `ID_EX` output.
- `ex_rd`  in  5  `rd` of the instruction currently in `ID_EX` output.
- `flush`  in  1  taken branch resolved downstream; squash the decoded instruction.
- `data_out`  out  `id_ex_data_t`  to `ID_EX.data_in`.
- `control_out`  out  `id_ex_control_t`  to `ID_EX.control_in`.
- `stall`  out  1  hold PC and IF/ID this cycle.

## Operation
Register file:
- Read: 2 combinational read ports, rs1 = `instr[19:15]`, rs2 = `instr[24:20]`.
- Write: 1 write port at the rising edge, when `wb_reg_write && wb_rd != 0`.
- Bypass: if `wb_reg_write && wb_rd != 0 && wb_rd == rsN`, `reg_read_dataN = wb_data` in the same cycle.
- `x0` always reads 0. A write to `x0` is discarded.

Decode (opcode = `instr[6:0]`):
- R `0110011`: reg_write=1, ALU_Op=10.
- I-ALU `0010011`: reg_write=1, ALU_Src=1, ALU_Op=11.
- LOAD `0000011`: reg_write=1, mem_to_reg=1, mem_read=1, ALU_Src=1, ALU_Op=00.
- STORE `0100011`: mem_write=1, ALU_Src=1, ALU_Op=00.
- BRANCH `1100011`: branch=1, ALU_Op=01.
- Any other opcode: all control fields 0 (bubble).

Immediates, sign-extended to 32 bits:
- I: `instr[31:20]`.
- S: `{instr[31:25],instr[11:7]}`.
- B: `{instr[31],instr[7],instr[30:25],instr[11:8],1'b0}` (byte offset).
- R and unknown opcodes: imm=0.

Other data fields:
- `funct_inst_bits = {instr[30], instr[14:12]}`.
- `rd = instr[11:7]`.
- `pc_address = if_id_pc`.

Hazard detection:
- rs1 is used by every defined opcode. rs2 is used by R, STORE and BRANCH only.
- `stall = ex_mem_read && ex_rd != 0 && ((ex_rd == rs1 && rs1 used) || (ex_rd == rs2 && rs2 used))`.

Bubble rules:
- If `stall || flush`, `control_out = '0`. Data fields still pass through and are don't-care.
- `flush` does not assert `stall`. When `flush` and a hazard coincide, `stall` is still driven from the equation above and `control_out` is 0.

## Timing
- Decode, immediate, hazard and read paths are purely combinational, with zero latency from `if_id_*` to `data_out`/`control_out`/`stall`.
- Register write takes effect at the rising edge. It is visible to reads in the same cycle through the bypass, and directly from the array afterwards.
- Load-use: one stall cycle. `ID_EX` latches a bubble. The next cycle `ex_mem_read` is 0 and decode proceeds.

Reset:
- Asserting `reset` immediately clears all 32 registers, including mid-operation and mid-stall.
- While `reset` is high: `control_out = '0`, `stall = 0`, writes are ignored, read data is 0 unless bypassed.
- The first write is accepted at the first rising edge after deassertion.

## Structure
- `cpu_pkg` gains:
  - opcode constants `OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`;
  - ALU_Op constants `ALUOP_MEM`=00, `ALUOP_BR`=01, `ALUOP_R`=10, `ALUOP_I`=11.
- `id_ex_data_t` and `id_ex_control_t` are reused unchanged.
- One sub-module, `reg_file`, holds the array: asynchronous reset, 1 write port, 2 read ports with bypass, `x0` rule.
- Decode, immediate generation and hazard detection live in `id_stage`.

## Test plan
1. Reset, then write x5=100 via WB; next cycle decode `add x6,x5,x5` → reg_read_data1=reg_read_data2=100, reg_write=1, ALU_Op=10, funct_inst_bits=0000, rd=6.
2. Same cycle: WB writes x7=0xDEADBEEF while decoding `sw x7,-4(x2)` → reg_read_data2=0xDEADBEEF (bypass), imm=0xFFFFFFFC, mem_write=1, reg_write=0.
3. WB writes x0=55, then decode `addi x1,x0,5` → reg_read_data1=0, imm=5, ALU_Src=1, ALU_Op=11.
4. ex_mem_read=1, ex_rd=3; decode `beq x3,x4,-8` → stall=1, control_out=0. Same with ex_rd=0 → stall=0, branch=1, imm=0xFFFFFFF8.
5. flush=1 with a valid LOAD in decode → control_out=0, stall=0. Unknown opcode 0x7F → control_out=0.
6. Write x9=42, assert reset for 3 ns mid-cycle, release → decode reading x9 gives 0 and control is 0 during reset.
